// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one full-adder cell bit-serially over two W-bit operands plus carry-in,
// with valid/ready request and result ports.
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    input  logic         abort,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count;
    logic [W-1:0]  a_sr, b_sr, sum_sr, sum_q, sum_nx;
    logic          carry, cout_q, s, c_nx, last;

    always_comb begin
        s        = a_sr[0] ^ b_sr[0] ^ carry;
        c_nx     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        sum_nx   = (sum_sr >> 1) | (W'(s) << (W - 1));
        last     = count == CW'(W - 1);
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_valid ? RUN : IDLE;
            RUN:     state_nx = abort ? IDLE : (last ? DONE : RUN);
            DONE:    state_nx = (abort || res_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start_valid) begin
                a_sr  <= op_a;
                b_sr  <= op_b;
                carry <= cin;
                count <= '0;
            end else if (state != IDLE && abort) begin
                carry  <= 1'b0;
                count  <= '0;
                sum_sr <= '0;
                sum_q  <= '0;
                cout_q <= 1'b0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                sum_sr <= sum_nx;
                carry  <= c_nx;
                count  <= count + CW'(1);
                // the published result only changes on the final bit, so it never shows partial sums
                if (last) begin
                    sum_q  <= sum_nx;
                    cout_q <= c_nx;
                end
            end
        end
    end

    assign start_ready = state == IDLE;
    assign busy        = state != IDLE;
    assign res_valid   = state == DONE;
    assign sum         = sum_q;
    assign cout        = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl (W=8 and W=1) against
// plain integer addition.
module tb_serial_add_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       sv8 = 1'b0, sv1 = 1'b0, cin = 1'b0, abort = 1'b0, res_ready = 1'b1;
    logic [7:0] op_a = '0, op_b = '0;
    logic       sr8, busy8, rv8, cout8, sr1, busy1, rv1, cout1;
    logic [7:0] sum8;
    logic [0:0] sum1;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .op_a(op_a), .op_b(op_b), .cin(cin), .abort(abort), .busy(busy8),
        .res_valid(rv8), .res_ready(res_ready), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
        .op_a(op_a[0:0]), .op_b(op_b[0:0]), .cin(cin), .abort(abort), .busy(busy1),
        .res_valid(rv1), .res_ready(res_ready), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; s selects the W=1 instance.
    task automatic run_op(input bit s, input logic [7:0] a, input logic [7:0] b, input logic c);
        int n, t, m;
        m = s ? 2 : 256;
        t = s ? int'(a[0]) + int'(b[0]) + int'(c) : int'(a) + int'(b) + int'(c);
        chk("start_ready", s ? sr1 : sr8, 1);
        op_a = a; op_b = b; cin = c;
        if (s) sv1 = 1'b1; else sv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv1 = 1'b0; sv8 = 1'b0;
        chk("busy_run", s ? busy1 : busy8, 1);
        n = 0;
        // scrambling the operand inputs during RUN must not disturb the result
        while (!(s ? rv1 : rv8) && n < 20) begin
            op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
            @(negedge clk);
            n++;
        end
        chk("latency", n, s ? 1 : 8);
        chk("sum", s ? {7'b0, sum1} : sum8, t % m);
        chk("cout", s ? cout1 : cout8, t / m);
        if (res_ready) begin
            @(negedge clk);
            chk("idle_after", s ? sr1 : sr8, 1);
        end
    endtask

    initial begin
        bit seen;
        #1;
        chk("rst_start_ready", sr8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_res_valid", rv8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        chk("rst_start_ready_w1", sr1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 8'h5A, 8'h33, 1'b0);
        run_op(0, 8'hFF, 8'h01, 1'b0);
        run_op(0, 8'hFF, 8'hFF, 1'b1);

        // backpressure: 0x3C+0x4B+1 = 0x88 held while res_ready is low
        res_ready = 1'b0;
        run_op(0, 8'h3C, 8'h4B, 1'b1);
        for (int i = 0; i < 5; i++) begin
            sv8 = 1'b1;
            @(negedge clk);
            chk("bp_res_valid", rv8, 1);
            chk("bp_sum", sum8, 8'h88);
            chk("bp_cout", cout8, 0);
            chk("bp_start_ready", sr8, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        sv8 = 1'b0;
        chk("release_start_ready", sr8, 1);
        chk("release_res_valid", rv8, 0);
        chk("release_sum_held", sum8, 8'h88);

        run_op(0, 8'h0F, 8'h01, 1'b0);

        // abort in the 3rd RUN cycle
        op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1; sv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_start_ready", sr8, 1);
        chk("abort_busy", busy8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_cout", cout8, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= rv8;
        end
        chk("abort_no_res_valid", seen, 0);
        run_op(0, 8'h01, 8'h01, 1'b0);

        // reset mid-RUN
        op_a = 8'h77; op_b = 8'h11; cin = 1'b0; sv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_start_ready", sr8, 1);
        chk("midrst_busy", busy8, 0);
        chk("midrst_res_valid", rv8, 0);
        chk("midrst_sum", sum8, 0);
        chk("midrst_cout", cout8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 8'h10, 8'h20, 1'b0);

        for (int i = 0; i < 8; i++)
            run_op(1, 8'(i >> 2), 8'((i >> 1) & 1), 1'(i & 1));

        for (int i = 0; i < 20; i++)
            run_op(0, 8'($urandom), 8'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
